// File: rtl/crc_pkg.sv
// Shared CRC constants (CRC-32 defaults) and a bit-reverse helper.
package crc_pkg;

  localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;
  localparam int          MAX_WIDTH    = 64;

  // Reverses the low 'width' bits of value; bits above 'width' come back zero.
  function automatic logic [63:0] bit_rev(input logic [63:0] value, input int width);
    logic [63:0] src;
    logic [63:0] res;
    src = value;
    res = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) begin
        res = {res[62:0], src[0]};
        src = src >> 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// Combinational single-byte CRC advance: eight MSB-first shift/XOR steps.
module crc_byte_step
  import crc_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(CRC32_POLY),
  parameter bit               REFIN = 1'b1
) (
  input  logic [WIDTH-1:0] state,
  input  logic [7:0]       data,
  output logic [WIDTH-1:0] next_state
);

  logic [WIDTH-1:0] acc;
  logic [7:0]       bits;
  logic             feedback;

  // Reflected input is handled by reversing the byte, so the register itself stays in normal form.
  always_comb begin
    bits     = REFIN ? 8'(bit_rev(64'(data), 8)) : data;
    acc      = state;
    feedback = 1'b0;
    for (int i = 0; i < 8; i++) begin
      feedback = acc[WIDTH-1] ^ bits[7];
      bits     = {bits[6:0], 1'b0};
      acc      = {acc[WIDTH-2:0], 1'b0};
      if (feedback) acc = acc ^ POLY;
    end
    next_state = acc;
  end

endmodule

// File: rtl/crc.sv
// Byte-wide streaming CRC with message framing via din_last and a one-cycle crc_valid pulse.
module crc
  import crc_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] POLY   = WIDTH'(CRC32_POLY),
  parameter logic [WIDTH-1:0] INIT   = WIDTH'(CRC32_INIT),
  parameter logic [WIDTH-1:0] XOROUT = WIDTH'(CRC32_XOROUT),
  parameter bit               REFIN  = 1'b1,
  parameter bit               REFOUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             din_valid,
  input  logic [7:0]       din,
  input  logic             din_last,
  output logic [WIDTH-1:0] crc_out,
  output logic             crc_valid
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] stepped;

  // The finished message's register is still visible during the crc_valid cycle;
  // anything absorbed in that cycle starts from INIT instead.
  always_comb begin
    base = (clear || crc_valid) ? INIT : state_q;
  end

  crc_byte_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .REFIN (REFIN)
  ) u_step (
    .state      (base),
    .data       (din),
    .next_state (stepped)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      crc_valid <= 1'b0;
    end else begin
      state_q   <= din_valid ? stepped : base;
      crc_valid <= din_valid & din_last;
    end
  end

  always_comb begin
    crc_out = (REFOUT ? WIDTH'(bit_rev(64'(state_q), WIDTH)) : state_q) ^ XOROUT;
  end

endmodule

// File: tb/tb_crc.sv
// Directed bench for crc: reference CRC-32 model plus scoreboard of finished-message results.
module tb_crc;

  localparam logic [31:0] MODEL_INIT = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        din_valid;
  logic [7:0]  din;
  logic        din_last;
  logic [31:0] crc_out;
  logic        crc_valid;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  int p0;

  logic [31:0] sb_q[$];
  logic [31:0] m;
  logic        reload;
  logic        exp_valid;

  logic [7:0] msg9[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  logic [7:0] msg_a[$] = '{8'h61};
  logic [7:0] msg_0[$] = '{8'h00};

  always #5 clk = ~clk;

  crc dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .din_valid (din_valid),
    .din       (din),
    .din_last  (din_last),
    .crc_out   (crc_out),
    .crc_valid (crc_valid)
  );

  // Reflected (LSB-first) CRC-32 byte update, register kept in reflected form.
  function automatic logic [31:0] ref_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic c, input logic v, input logic [7:0] d, input logic l);
    logic [31:0] base;
    logic [31:0] got;
    rst = r; clear = c; din_valid = v; din = d; din_last = l;
    if (r) begin
      m = MODEL_INIT;
      exp_valid = 1'b0;
    end else begin
      base = (c || reload) ? MODEL_INIT : m;
      m = v ? ref_upd(base, d) : base;
      exp_valid = v & l;
      if (v && l) sb_q.push_back(m ^ 32'hFFFFFFFF);
    end
    reload = exp_valid;
    @(posedge clk);
    #1;
    check("crc_valid", {31'b0, crc_valid}, {31'b0, exp_valid});
    check("crc_out_running", crc_out, m ^ 32'hFFFFFFFF);
    if (crc_valid === 1'b1) begin
      pulses++;
      check("sb_depth", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() > 0) begin
        got = sb_q.pop_front();
        check("sb_result", crc_out, got);
      end
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_msg(input logic [7:0] bytes[$], input logic clr_first, input logic [31:0] lit);
    for (int i = 0; i < bytes.size(); i++)
      cycle(1'b0, clr_first && (i == 0), 1'b1, bytes[i], i == bytes.size() - 1);
    check("literal_crc", crc_out, lit);
  endtask

  initial begin
    m = MODEL_INIT;
    reload = 1'b0;
    exp_valid = 1'b0;

    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    check("reset_crc_out", crc_out, 32'h00000000);
    idle(); idle(); idle();

    send_msg(msg9, 1'b0, 32'hCBF43926);
    idle();
    send_msg(msg_a, 1'b0, 32'hE8B7BE43);
    idle();
    send_msg(msg_0, 1'b0, 32'hD202EF8D);
    idle();

    p0 = pulses;
    send_msg(msg_a, 1'b0, 32'hE8B7BE43);
    send_msg(msg9, 1'b0, 32'hCBF43926);
    idle();
    check("b2b_pulses", 32'(pulses - p0), 32'd2);

    p0 = pulses;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, msg9[i], 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    send_msg(msg9, 1'b0, 32'hCBF43926);
    idle();
    check("abort_pulses", 32'(pulses - p0), 32'd1);

    cycle(1'b0, 1'b0, 1'b0, 8'h39, 1'b1);
    idle();

    cycle(1'b0, 1'b0, 1'b1, 8'h41, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h42, 1'b0);
    send_msg(msg9, 1'b1, 32'hCBF43926);
    idle();

    cycle(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check("zero_len_crc", crc_out, 32'h00000000);
    idle();

    cycle(1'b0, 1'b0, 1'b1, 8'h31, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 8'h32, 1'b1);
    check("rst_priority_crc", crc_out, 32'h00000000);
    idle();

    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crc.md
CRC -- requirements
Module: crc

Interface
REQ-001 Parameter WIDTH, 32, CRC register width in bits; legal 8..64.
REQ-002 Parameter POLY, 32'h04C11DB7, generator polynomial in normal (MSB-first) form, implicit x^WIDTH term.
REQ-003 Parameter INIT, 32'hFFFFFFFF, register value after reset or clear.
REQ-004 Parameter XOROUT, 32'hFFFFFFFF, value XORed onto the register to form crc_out.
REQ-005 Parameter REFIN, 1, 1 = each input byte processed LSB-first (reflected).
REQ-006 Parameter REFOUT, 1, 1 = register bit-reversed before the XOROUT step.
REQ-007 clk  input  1  single clock; all state changes on the rising edge.
REQ-008 rst  input  1  reset, synchronous and active-high.
REQ-009 clear  input  1  synchronous reinit of the register to INIT.
REQ-010 din_valid  input  1  din holds a byte to be absorbed this cycle.
REQ-011 din  input  8  data byte.
REQ-012 din_last  input  1  qualifies din_valid; marks the final byte of a message.
REQ-013 crc_out  output  WIDTH  finalized CRC of all bytes absorbed since the last INIT load.
REQ-014 crc_valid  output  1  one-cycle pulse; crc_out is final for a completed message.

Function
REQ-015 The block SHALL accept one byte per cycle with no backpressure; no ready output exists.
REQ-016 On a rising edge with din_valid=1, the register SHALL absorb all 8 bits of din in that cycle: 8 shift-XOR steps with POLY, bit order set by REFIN.
REQ-017 crc_out SHALL be a combinational function of the register only: optional reflection (REFOUT), then XOR with XOROUT.
REQ-018 Latency: crc_out SHALL reflect a byte on the rising edge after that byte is presented.
REQ-019 crc_valid SHALL be registered and SHALL go to 1 for exactly one cycle, namely the cycle after a cycle with din_valid=1 and din_last=1.
REQ-020 The register SHALL reload INIT in the cycle after crc_valid, so the next message starts clean.
REQ-021 din_last with din_valid=0 SHALL be ignored.
REQ-022 clear=1 with din_valid=0 SHALL load INIT and SHALL force crc_valid=0 next cycle.
REQ-023 clear=1 together with din_valid=1 SHALL absorb din into INIT rather than into the old register value; crc_valid follows din_last as usual.
REQ-024 Back-to-back messages SHALL be supported: a new byte in the crc_valid cycle SHALL be absorbed into INIT, and crc_out/crc_valid of the prior message SHALL remain correct.
REQ-025 A zero-length message (clear only) SHALL give crc_out = INIT transformed by REQ-017.

Reset
REQ-026 rst SHALL set the register to INIT and crc_valid to 0 on the next rising edge; rst SHALL take priority over clear and din_valid.
REQ-027 Reset mid-message SHALL discard all absorbed bytes; no crc_valid SHALL be produced for the aborted message.

Structure
REQ-028 Package crc_pkg SHALL hold the default CRC-32 constants (POLY, INIT, XOROUT) and a bit-reverse function.
REQ-029 Sub-module crc_byte_step SHALL be purely combinational, parameterized like crc, with inputs (state, byte) and output next_state.

Verification
REQ-030 Default parameters; rst, then bytes "123456789" (0x31..0x39), last on 0x39 -> crc_valid pulse, crc_out=32'hCBF43926.
REQ-031 Single byte 0x61 with din_last -> crc_out=32'hE8B7BE43; single byte 0x00 with din_last -> 32'hD202EF8D.
REQ-032 After rst with no data -> crc_out=32'h00000000 and crc_valid stays 0.
REQ-033 Two back-to-back messages, "a" then "123456789", with no idle cycle -> crc_out=E8B7BE43 then CBF43926, each with one crc_valid pulse.
REQ-034 Abort test: rst after bytes 0x31..0x34, then the full "123456789" -> CBF43926 and exactly one crc_valid pulse.
REQ-035 clear asserted together with the first byte 0x31 while the register holds stale data -> final result CBF43926.
